// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding and the default datapath width / iteration
// count.
// -----------------------------------------------------------------------------
package mdu_pkg;

   // Default operand / HI / LO width; the unit runs one iteration per bit.
   localparam int MDU_WIDTH = 32;
   localparam int MDU_ITER  = MDU_WIDTH;

   // Operation encodings as presented on op. Bit 1 selects divide, bit 0
   // selects unsigned.
   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   // Control FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } mdu_state_e;

endpackage : mdu_pkg

// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Execute-stage connection to the multiply/divide unit.
//   start/op/in_rs/in_rt : operation launch (sampled only when busy=0)
//   hi_we/lo_we/wdata    : mthi / mtlo writes
//   busy/done/div_by_zero: status back to pipeline control
//   hi/lo                : architectural HI/LO registers (mfhi / mflo)
// master = pipeline side, slave = multiply/divide unit.
// -----------------------------------------------------------------------------
interface mult_div_unit_if #(
   parameter int WIDTH = 32
) ();

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] in_rs;
   logic [WIDTH-1:0] in_rt;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, in_rs, in_rt, hi_we, lo_we, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, in_rs, in_rt, hi_we, lo_we, wdata,
      output busy, done, div_by_zero, hi, lo
   );

endinterface : mult_div_unit_if

// File: rtl/mdu_step.sv
// -----------------------------------------------------------------------------
// mdu_step
// Combinational single iteration of the multiply/divide datapath.
//   i_op   : latched operation; divide ops select shift-subtract, multiply
//            ops select shift-add
//   i_opnd : multiplicand (multiply) or divisor (divide), magnitude
//   i_rem  : upper accumulator half (multiply) or partial remainder (divide)
//   i_quo  : lower accumulator half / multiplier (multiply) or
//            dividend-shifting-into-quotient register (divide)
//   o_rem / o_quo : values after this iteration
// -----------------------------------------------------------------------------
module mdu_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  mdu_op_e          i_op,
   input  logic [WIDTH-1:0] i_opnd,
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic             w_is_div;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;

   // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
   always_comb begin
      w_is_div = (i_op == MDU_DIV) || (i_op == MDU_DIVU);

      // Multiply: add multiplicand to the upper half when the multiplier LSB
      // is set, then shift the whole 2*WIDTH accumulator right by one. The
      // carry out of the add becomes the new MSB of the upper half.
      w_sum = {1'b0, i_rem} +
              (i_quo[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});

      // Divide: bring the next dividend bit into the remainder. The partial
      // remainder is always below the divisor, so WIDTH+1 bits hold the
      // shifted value and the stored remainder fits in WIDTH bits.
      w_shift = {i_rem, i_quo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, i_opnd};

      o_rem = w_sum[WIDTH:1];
      o_quo = {w_sum[0], i_quo[WIDTH-1:1]};

      if (w_is_div) begin
         if (w_diff[WIDTH] == 1'b0) begin
            o_rem = w_diff[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
         end else begin
            // Restore: the subtraction went negative, keep the shifted value.
            o_rem = w_shift[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
         end
      end else begin
         o_rem = w_sum[WIDTH:1];
         o_quo = {w_sum[0], i_quo[WIDTH-1:1]};
      end
   end

endmodule : mdu_step

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit beside the execute-stage ALU. Runs mult,
// multu, div and divu one bit per cycle and owns the HI/LO registers.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset; abandons any operation
//   bus     : mult_div_unit_if.slave
//             start/op/in_rs/in_rt launch an operation when busy=0
//             hi_we/lo_we/wdata perform mthi/mtlo when busy=0
//             busy high in CALC and FIX; done (+div_by_zero) high in DONE
//             hi/lo are the architectural registers
// Timing from the launch edge T: CALC over T+1..T+WIDTH, FIX at T+WIDTH+1
// (result written at the edge leaving FIX), DONE at T+WIDTH+2. A divide by
// zero goes straight to DONE at T+1 and leaves HI/LO untouched.
// -----------------------------------------------------------------------------
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input logic                    clk,
   input logic                    reset_n,
   mult_div_unit_if.slave         bus
);

   localparam int CNT_W = $clog2(WIDTH);

   mdu_state_e         r_state;
   logic [CNT_W-1:0]   r_cnt;
   mdu_op_e            r_op;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_busy;
   logic               r_done;
   logic               r_dbz;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_signed;
   logic               w_is_div;
   logic               w_rs_neg;
   logic               w_rt_neg;
   logic [WIDTH-1:0]   w_rs_mag;
   logic [WIDTH-1:0]   w_rt_mag;
   logic               w_div_zero;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   logic [WIDTH-1:0]   w_step_rem;
   logic [WIDTH-1:0]   w_step_quo;

   // Two's-complement negate when neg is set.
   function automatic logic [WIDTH-1:0] cond_neg(input logic neg,
                                                 input logic [WIDTH-1:0] val);
      return neg ? (~val + WIDTH'(1'b1)) : val;
   endfunction

   // Launch-time operand conditioning: magnitudes for signed ops, raw otherwise.
   always_comb begin
      w_signed   = ~bus.op[0];
      w_is_div   = bus.op[1];
      w_rs_neg   = w_signed & bus.in_rs[WIDTH-1];
      w_rt_neg   = w_signed & bus.in_rt[WIDTH-1];
      w_rs_mag   = cond_neg(w_rs_neg, bus.in_rs);
      w_rt_mag   = cond_neg(w_rt_neg, bus.in_rt);
      w_div_zero = w_is_div & (bus.in_rt == {WIDTH{1'b0}});
   end

   // Final sign correction applied in FIX.
   always_comb begin
      w_prod     = {r_rem, r_quo};
      w_prod_fix = r_neg_q ? (~w_prod + (2*WIDTH)'(1'b1)) : w_prod;
      w_quo_fix  = cond_neg(r_neg_q, r_quo);
      w_rem_fix  = cond_neg(r_neg_r, r_rem);
   end

   mdu_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_op   (r_op),
      .i_opnd (r_opnd),
      .i_rem  (r_rem),
      .i_quo  (r_quo),
      .o_rem  (w_step_rem),
      .o_quo  (w_step_quo)
   );

   // Control FSM, iteration counter, sign latches and HI/LO registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= {CNT_W{1'b0}};
         r_op    <= MDU_MULT;
         r_opnd  <= {WIDTH{1'b0}};
         r_rem   <= {WIDTH{1'b0}};
         r_quo   <= {WIDTH{1'b0}};
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_hi    <= {WIDTH{1'b0}};
         r_lo    <= {WIDTH{1'b0}};
      end else begin
         case (r_state)
            IDLE, DONE: begin
               // Not busy here, so mthi/mtlo take effect. A launch in the
               // same cycle is fine: its result lands much later in FIX.
               if (bus.hi_we) begin
                  r_hi <= bus.wdata;
               end else begin
                  r_hi <= r_hi;
               end
               if (bus.lo_we) begin
                  r_lo <= bus.wdata;
               end else begin
                  r_lo <= r_lo;
               end

               if (bus.start) begin
                  r_op    <= mdu_op_e'(bus.op);
                  r_neg_q <= w_rs_neg ^ w_rt_neg;
                  r_neg_r <= w_rs_neg & w_is_div;
                  r_rem   <= {WIDTH{1'b0}};
                  r_cnt   <= {CNT_W{1'b0}};
                  // Multiply shifts the multiplier through the low half;
                  // divide shifts the dividend through the quotient register.
                  r_opnd  <= w_is_div ? w_rt_mag : w_rs_mag;
                  r_quo   <= w_is_div ? w_rs_mag : w_rt_mag;
                  if (w_div_zero) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_dbz   <= 1'b1;
                  end else begin
                     r_state <= CALC;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b0;
                     r_dbz   <= 1'b0;
                  end
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
                  r_dbz   <= 1'b0;
               end
            end

            CALC: begin
               r_rem <= w_step_rem;
               r_quo <= w_step_quo;
               r_cnt <= r_cnt + CNT_W'(1'b1);
               if (r_cnt == CNT_W'(WIDTH-1)) begin
                  r_state <= FIX;
               end else begin
                  r_state <= CALC;
               end
            end

            FIX: begin
               if ((r_op == MDU_DIV) || (r_op == MDU_DIVU)) begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quo_fix;
               end else begin
                  r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_fix[WIDTH-1:0];
               end
               r_state <= DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_dbz   <= 1'b0;
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_dbz   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.div_by_zero = r_dbz;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;

endmodule : mult_div_unit
